mp_add_seq: RTL and testbench

Multi-precision add/subtract sequencer built around the team's existing 8-bit ripple-carry adder (module RippleCarry; ports x1, x2, cin, y, cout).
- Accepts two NUM_BYTES-wide operands over a valid/ready handshake.
- Feeds them to the single adder one byte per cycle, LSB first, chaining the carry through a register.
- Returns the full-width result over a second valid/ready handshake.
- Lets one small adder serve wide arithmetic in a datapath.

---
 rtl/mp_add_pkg.sv | 20 ++
 rtl/mp_add_seq_adder.sv | 27 ++
 rtl/mp_add_seq.sv | 160 ++++++++++++++++
 tb/tb_mp_add_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared definitions for the multi-precision add/subtract sequencer.
//   BYTE_W      - width of one adder slice (bits)
//   mp_state_t  - sequencer FSM states
//   idx_width() - width of the byte index register for a given byte count
package mp_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mp_state_t;

    // A single-byte operand still needs a 1-bit index register.
    function automatic int idx_width(input int num_bytes);
        return (num_bytes < 2) ? 1 : $clog2(num_bytes);
    endfunction

endpackage

// File: rtl/mp_add_seq_adder.sv
// RippleCarry: 8-bit ripple-carry adder slice.
//   x1, x2 - addend bytes
//   cin    - carry into bit 0
//   y      - sum byte
//   cout   - carry out of bit 7
module RippleCarry (
    input  logic [7:0] x1,
    input  logic [7:0] x2,
    input  logic       cin,
    output logic [7:0] y,
    output logic       cout
);

    logic [8:0] c;

    always_comb begin
        c    = '0;
        y    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            y[i]     = x1[i] ^ x2[i] ^ c[i];
            c[i + 1] = (x1[i] & x2[i]) | (c[i] & (x1[i] ^ x2[i]));
        end
        cout = c[8];
    end

endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add/subtract sequencer. Operands are taken on a
// valid/ready start handshake, pushed through one 8-bit RippleCarry adder LSB
// byte first with the carry chained through a register, and returned on a
// valid/ready done handshake.
//   clk, rst          - clock, asynchronous active-high reset
//   start_valid/ready - request handshake; a, b, cin, sub sampled on it
//   result, cout      - sum/difference and final carry (not-borrow for sub)
//   done_valid/ready  - result handshake
//   busy              - operation in progress or result pending
//   ovf               - signed overflow, present only with MP_ADD_SEQ_OVF_EN
//
// state | meaning
// IDLE  | waiting for start_valid; start_ready high
// RUN   | one operand byte through the adder per cycle
// DONE  | result and cout held until done_ready
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_valid,
    output logic                        start_ready,
    input  logic [BYTE_W*NUM_BYTES-1:0] a,
    input  logic [BYTE_W*NUM_BYTES-1:0] b,
    input  logic                        cin,
    input  logic                        sub,
    output logic [BYTE_W*NUM_BYTES-1:0] result,
    output logic                        cout,
    output logic                        done_valid,
    input  logic                        done_ready,
    output logic                        busy
`ifdef MP_ADD_SEQ_OVF_EN
    ,
    output logic                        ovf
`endif
);

    localparam int W     = BYTE_W * NUM_BYTES;
    localparam int IDX_W = idx_width(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    mp_state_t        state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     result_q, result_d;
    logic             cout_q, cout_d;
    logic             done_valid_q, done_valid_d;
`ifdef MP_ADD_SEQ_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [BYTE_W-1:0] add_x1, add_x2, add_y;
    logic              add_cout;

    // Subtraction is A + ~B + ~cin: invert B here, invert cin at accept.
    assign add_x1 = a_q[idx_q*BYTE_W +: BYTE_W];
    assign add_x2 = sub_q ? ~b_q[idx_q*BYTE_W +: BYTE_W] : b_q[idx_q*BYTE_W +: BYTE_W];

    RippleCarry u_adder (
        .x1   (add_x1),
        .x2   (add_x2),
        .cin  (carry_q),
        .y    (add_y),
        .cout (add_cout)
    );

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sub_d        = sub_q;
        carry_d      = carry_q;
        idx_d        = idx_q;
        result_d     = result_q;
        cout_d       = cout_q;
        done_valid_d = done_valid_q;
`ifdef MP_ADD_SEQ_OVF_EN
        ovf_d        = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d      = a;
                    b_d      = b;
                    sub_d    = sub;
                    carry_d  = sub ? ~cin : cin;
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d[idx_q*BYTE_W +: BYTE_W] = add_y;
                carry_d = add_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d       = add_cout;
                    done_valid_d = 1'b1;
                    state_d      = DONE;
`ifdef MP_ADD_SEQ_OVF_EN
                    // Carry into the top bit is recovered from that bit's sum.
                    ovf_d = (add_x1[BYTE_W-1] ^ add_x2[BYTE_W-1] ^ add_y[BYTE_W-1]) ^ add_cout;
`endif
                end
            end
            DONE: begin
                if (done_ready) begin
                    done_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sub_q        <= 1'b0;
            carry_q      <= 1'b0;
            idx_q        <= '0;
            result_q     <= '0;
            cout_q       <= 1'b0;
            done_valid_q <= 1'b0;
`ifdef MP_ADD_SEQ_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sub_q        <= sub_d;
            carry_q      <= carry_d;
            idx_q        <= idx_d;
            result_q     <= result_d;
            cout_q       <= cout_d;
            done_valid_q <= done_valid_d;
`ifdef MP_ADD_SEQ_OVF_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign result      = result_q;
    assign cout        = cout_q;
    assign done_valid  = done_valid_q;
`ifdef MP_ADD_SEQ_OVF_EN
    assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_mp_add_seq.sv
module tb_mp_add_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         done_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         start_ready, cout, done_valid, busy;
    logic [W-1:0] result;
`ifdef MP_ADD_SEQ_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mp_add_seq #(.NUM_BYTES(NB)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .sub         (sub),
        .result      (result),
        .cout        (cout),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .busy        (busy)
`ifdef MP_ADD_SEQ_OVF_EN
        ,
        .ovf         (ovf)
`endif
    );

    task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain wide unsigned / signed math.
    function automatic void ref_calc(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                     input logic rc, input logic rs,
                                     output logic [W-1:0] r, output logic co, output logic ov);
        logic [63:0] ua, ub, u;
        longint      sa, sb, s;
        ua = {32'b0, ra};
        ub = {32'b0, rb};
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        if (!rs) begin
            u  = ua + ub + 64'(rc);
            co = u[W];
            s  = sa + sb + longint'(rc);
        end else begin
            u  = ua - ub - 64'(rc);
            co = (ua >= ub + 64'(rc));
            s  = sa - sb - longint'(rc);
        end
        r  = u[W-1:0];
        ov = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
    endfunction

    // Transaction-level model: accept when idle, result visible byte by byte
    // over NB cycles, then held until the consumer takes it.
    logic         m_run = 1'b0, m_done = 1'b0;
    int           m_k = 0;
    logic [W-1:0] m_pend = '0;
    logic         m_cout = 1'b0, m_ovf = 1'b0, p_cout = 1'b0, p_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run  = 1'b0;
            m_done = 1'b0;
            m_k    = 0;
            m_pend = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_run) begin
            m_k++;
            if (m_k == NB) begin
                m_run  = 1'b0;
                m_done = 1'b1;
                m_cout = p_cout;
                m_ovf  = p_ovf;
            end
        end else if (m_done) begin
            if (done_ready) m_done = 1'b0;
        end else if (start_valid) begin
            ref_calc(a, b, cin, sub, m_pend, p_cout, p_ovf);
            m_k   = 0;
            m_run = 1'b1;
        end
    end

    always @(negedge clk) begin : cmp_blk
        logic [W-1:0] mask;
        mask = (m_k >= NB) ? '1 : W'((64'd1 << (8 * m_k)) - 64'd1);
        check_b("start_ready", start_ready, !(m_run || m_done));
        check_b("busy", busy, m_run || m_done);
        check_b("done_valid", done_valid, m_done);
        check_w("result", result, m_pend & mask);
        check_b("cout", cout, m_cout);
`ifdef MP_ADD_SEQ_OVF_EN
        check_b("ovf", ovf, m_ovf);
`endif
    end

    // Called just after a rising edge with the DUT idle; returns likewise.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tci, input logic tsb, input int hold,
                          input bit lit, input logic [W-1:0] er, input logic ec);
        int lat;
        a           = ta;
        b           = tb_v;
        cin         = tci;
        sub         = tsb;
        start_valid = 1'b1;
        done_ready  = (hold == 0);
        @(posedge clk); #1;
        start_valid = 1'($urandom_range(0, 1));
        a           = $urandom;
        b           = $urandom;
        cin         = 1'($urandom_range(0, 1));
        sub         = 1'($urandom_range(0, 1));
        lat = 0;
        while (!done_valid && lat < NB + 4) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: done_valid still 0 after %0d cycles, required by %0d", lat, NB);
            start_valid = 1'b0;
            done_ready  = 1'b1;
            return;
        end
        if (lit) begin
            check_w("latency", W'(lat), W'(NB));
            check_w("lit_result", result, er);
            check_b("lit_cout", cout, ec);
        end
        for (int i = 0; i < hold; i++) begin
            start_valid = 1'b1;
            @(posedge clk); #1;
            if (lit) begin
                check_w("hold_result", result, er);
                check_b("hold_cout", cout, ec);
                check_b("hold_done_valid", done_valid, 1'b1);
                check_b("hold_start_ready", start_ready, 1'b0);
            end
        end
        done_ready = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        if (lit) begin
            check_b("ready_after_done", start_ready, 1'b1);
            check_b("done_fell", done_valid, 1'b0);
        end
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return '1;
            1:       return 32'h8000_0000;
            2:       return '0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2;
        check_w("reset_result", result, '0);
        check_b("reset_start_ready", start_ready, 1'b1);
        check_b("reset_done_valid", done_valid, 1'b0);
        check_b("reset_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b1, 32'h0000_0000, 1'b1);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 0, 1'b1, 32'h2345_678A, 1'b0);
        run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        run_op(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 0, 1'b1, 32'h0000_0002, 1'b1);
        run_op(32'hF000_0000, 32'h2000_0001, 1'b0, 1'b0, 3, 1'b1, 32'h1000_0001, 1'b1);

        // Reset two cycles into RUN, leaving a partial result and cout=1.
        a = 32'h1111_1111;
        b = 32'h2222_2222;
        cin = 1'b0;
        sub = 1'b0;
        start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        check_w("midrst_result", result, '0);
        check_b("midrst_cout", cout, 1'b0);
        check_b("midrst_done_valid", done_valid, 1'b0);
        check_b("midrst_busy", busy, 1'b0);
        check_b("midrst_start_ready", start_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_b("post_rst_start_ready", start_ready, 1'b1);
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b1, 32'h0000_0002, 1'b0);

`ifdef MP_ADD_SEQ_OVF_EN
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b1, 32'h8000_0000, 1'b0);
        check_b("ovf_add", ovf, 1'b1);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0, 1'b1, 32'h7FFF_FFFF, 1'b1);
        check_b("ovf_sub", ovf, 1'b1);
        run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 0, 1'b1, 32'h0000_0007, 1'b0);
        check_b("ovf_none", ovf, 1'b0);
`endif

        for (int n = 0; n < 150; n++) begin
            run_op(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, '0, 1'b0);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
